// File: rtl/svm_cfg_pkg.sv
// Shared constants and types for the hog_svm configuration loader.
package svm_cfg_pkg;

  localparam int unsigned FEA_I  = 4;
  localparam int unsigned FEA_F  = 8;
  localparam int unsigned ROW    = 15;
  localparam int unsigned COL    = 7;
  localparam int unsigned N_WORD = 36;
  localparam int unsigned ADDR_W = 6;

  localparam int unsigned COEF_W = FEA_I + FEA_F;
  localparam int unsigned N_COEF = ROW * COL;
  localparam int unsigned RAM_DW = COEF_W * N_COEF;
  localparam int unsigned LANE_W = $clog2(N_COEF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_COEF,
    WRITE,
    LOAD_BIAS,
    DONE
  } cfg_state_t;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [RAM_DW-1:0]        ram_word_t;

  // One coefficient RAM port-A write
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    ram_word_t         data;
  } ram_wr_t;

endpackage

// File: rtl/svm_cfg_loader_if.sv
// Host coefficient stream: one Q4.8 value per valid/ready beat.
interface svm_cfg_loader_if;
  import svm_cfg_pkg::*;

  logic  s_valid;
  logic  s_ready;
  coef_t s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/svm_coef_packer.sv
// Packs N_COEF narrow coefficients into one RAM word; first beat ends in lane 0.
module svm_coef_packer
  import svm_cfg_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      shift_en,
  input  coef_t     data,
  output ram_word_t pack_nxt_c,
  output logic      wrap_c
);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N_COEF - 1);

  ram_word_t         pack_q;
  logic [LANE_W-1:0] lane_q;
  logic [LANE_W-1:0] lane_d;

  // New beat enters the top lane, older beats move one lane toward lane 0
  always_comb begin
    pack_nxt_c = {data, pack_q[RAM_DW-1:COEF_W]};
    wrap_c     = shift_en && (lane_q == LANE_LAST);
    lane_d     = lane_q;
    if (clr) begin
      lane_d = '0;
    end else if (shift_en) begin
      lane_d = wrap_c ? '0 : lane_q + LANE_W'(1);
    end
  end

  // Pack register and lane counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_q <= '0;
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
      if (clr) begin
        pack_q <= '0;
      end else if (shift_en) begin
        pack_q <= pack_nxt_c;
      end
    end
  end

endmodule

// File: rtl/svm_cfg_loader.sv
// Configuration sequencer: streams coefficients into the SVM RAM, then loads
// the bias and enables the HOG pixel path only on a fully loaded model.
module svm_cfg_loader
  import svm_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  svm_cfg_loader_if.slave   cfg,
  output logic [ADDR_W-1:0] addr_a,
  output logic              write_en,
  output ram_word_t         i_data_a,
  output coef_t             bias,
  output logic              b_load,
  output logic              busy,
  output logic              cfg_done,
  output logic              hog_en
);

  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(N_WORD - 1);

  cfg_state_t        state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  ram_wr_t           wr_q, wr_d;
  coef_t             bias_d;
  logic              s_ready_q, s_ready_d;
  logic              write_en_d;
  logic              b_load_d;
  logic              busy_d;
  logic              cfg_done_d;
  logic              xfer_c;
  logic              shift_en_c;
  logic              clr_c;
  ram_word_t         pack_nxt_c;
  logic              wrap_c;

  assign cfg.s_ready = s_ready_q;
  assign addr_a      = wr_q.addr;
  assign i_data_a    = wr_q.data;
  assign xfer_c      = cfg.s_valid && s_ready_q;

  svm_coef_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_c),
    .shift_en   (shift_en_c),
    .data       (cfg.s_data),
    .pack_nxt_c (pack_nxt_c),
    .wrap_c     (wrap_c)
  );

  // Next state, word counter and next values of every registered output
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    wr_d       = wr_q;
    bias_d     = bias;
    write_en_d = 1'b0;
    b_load_d   = 1'b0;
    shift_en_c = 1'b0;
    clr_c      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD_COEF;
          word_d  = '0;
          clr_c   = 1'b1;
        end
      end
      LOAD_COEF: begin
        if (xfer_c) begin
          shift_en_c = 1'b1;
          if (wrap_c) begin
            state_d    = WRITE;
            write_en_d = 1'b1;
            wr_d.addr  = word_q;
            wr_d.data  = pack_nxt_c;
          end
        end
      end
      WRITE: begin
        if (word_q == WORD_LAST) begin
          word_d  = '0;
          state_d = LOAD_BIAS;
        end else begin
          word_d  = word_q + ADDR_W'(1);
          state_d = LOAD_COEF;
        end
      end
      LOAD_BIAS: begin
        if (xfer_c) begin
          bias_d   = cfg.s_data;
          b_load_d = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d  = (state_d == LOAD_COEF) || (state_d == LOAD_BIAS);
    busy_d     = (state_d == LOAD_COEF) || (state_d == WRITE) || (state_d == LOAD_BIAS);
    // Model is only valid once DONE has settled; a restart drops it at once
    cfg_done_d = (state_q == DONE) && (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      wr_q      <= '0;
      bias      <= '0;
      s_ready_q <= 1'b0;
      write_en  <= 1'b0;
      b_load    <= 1'b0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
      hog_en    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      wr_q      <= wr_d;
      bias      <= bias_d;
      s_ready_q <= s_ready_d;
      write_en  <= write_en_d;
      b_load    <= b_load_d;
      busy      <= busy_d;
      cfg_done  <= cfg_done_d;
      hog_en    <= cfg_done_d;
    end
  end

endmodule

// File: tb/tb_svm_cfg_loader.sv
// Randomized bench for svm_cfg_loader with a beat-count reference model.
module tb_svm_cfg_loader;
  import svm_cfg_pkg::*;

  localparam int NC = N_COEF;
  localparam int NW = N_WORD;
  localparam int NB = NW * NC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [ADDR_W-1:0] addr_a;
  logic              write_en;
  ram_word_t         i_data_a;
  coef_t             bias;
  logic              b_load, busy, cfg_done, hog_en;

  svm_cfg_loader_if cfg_if ();

  svm_cfg_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg      (cfg_if),
    .addr_a   (addr_a),
    .write_en (write_en),
    .i_data_a (i_data_a),
    .bias     (bias),
    .b_load   (b_load),
    .busy     (busy),
    .cfg_done (cfg_done),
    .hog_en   (hog_en)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input ram_word_t act, input ram_word_t exp);
    total++;
    if (act !== exp) begin
      int l;
      l = 0;
      bad++;
      for (int i = NC - 1; i >= 0; i--)
        if (act[i*COEF_W +: COEF_W] !== exp[i*COEF_W +: COEF_W]) l = i;
      $display("FAIL %s: lane %0d got %03h expected %03h at %0t", nm, l,
               act[l*COEF_W +: COEF_W], exp[l*COEF_W +: COEF_W], $time);
    end
  endtask

  // ---------------- reference model (beat counting) ----------------
  coef_t             m_beats [NB];
  bit                m_active, m_wr, m_done;
  int                m_n;
  int                cyc = 0;
  int                first_cyc = 0;
  logic              e_ready, e_busy, e_we, e_bload, e_done;
  logic [ADDR_W-1:0] e_addr;
  ram_word_t         e_data;
  coef_t             e_bias;

  function automatic ram_word_t m_word(input int w);
    ram_word_t r;
    r = '0;
    for (int l = 0; l < NC; l++) r[l*COEF_W +: COEF_W] = m_beats[w*NC + l];
    return r;
  endfunction

  // Each configuration takes NB coefficients (one write slot after every NC) plus one bias
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_wr = 0; m_done = 0; m_n = 0;
      e_ready = 0; e_busy = 0; e_we = 0; e_bload = 0; e_done = 0;
      e_addr = '0; e_data = '0; e_bias = '0;
    end else begin
      bit xfer, was_done;
      cyc++;
      xfer = cfg_if.s_valid && e_ready;
      was_done = m_done;
      e_we = 0;
      e_bload = 0;
      if (m_active) begin
        if (m_wr) m_wr = 0;
        else if (xfer) begin
          if (m_n < NB) begin
            if (m_n == 0) first_cyc = cyc;
            m_beats[m_n] = cfg_if.s_data;
            m_n++;
            if (m_n % NC == 0) begin
              m_wr = 1;
              e_we = 1;
              e_addr = ADDR_W'(m_n / NC - 1);
              e_data = m_word(m_n / NC - 1);
            end
          end else begin
            e_bias = cfg_if.s_data;
            e_bload = 1;
            m_active = 0;
            m_done = 1;
          end
        end
      end else if (start) begin
        m_active = 1;
        m_n = 0;
        m_done = 0;
      end
      e_done  = was_done && m_done;
      e_ready = m_active && !m_wr;
      e_busy  = m_active;
    end
  end

  // ---------------- per-cycle compare + literal pins ----------------
  int    wr_cnt = 0;
  int    bl_cnt = 0;
  int    pin_mode = 2;
  bit    chk_lat = 0;
  coef_t pin_bias = 12'h0A0;
  bit    prev_bload = 0;
  bit    hung = 0;

  function automatic ram_word_t desc_word(input int w);
    ram_word_t r;
    for (int l = 0; l < NC; l++) r[l*COEF_W +: COEF_W] = 12'(3779 - (w*105 + l));
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("s_ready", cfg_if.s_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("write_en", write_en, e_we);
      chk("addr_a", addr_a, e_addr);
      chk_w("i_data_a", i_data_a, e_data);
      chk("b_load", b_load, e_bload);
      chk("bias", bias, e_bias);
      chk("cfg_done", cfg_done, e_done);
      chk("hog_en", hog_en, e_done);
      if (write_en) begin
        chk("addr_order", addr_a, wr_cnt);
        if (pin_mode == 0) chk_w("desc_word", i_data_a, desc_word(wr_cnt));
        else if (pin_mode == 1) chk_w("ones_word", i_data_a, '1);
        // first beat's cycle counts as cycle 1
        if (chk_lat && wr_cnt == 0) chk("first_write_cycle", cyc - first_cyc + 2, 106);
        wr_cnt++;
      end
      if (b_load) begin
        bl_cnt++;
        chk("bias_pin", bias, pin_bias);
      end
      if (prev_bload) chk("done_after_bload", {cfg_done, hog_en}, 2'b11);
      prev_bload = b_load;
    end else begin
      prev_bload = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input coef_t d, input int duty, input bit pulse);
    bit took;
    int guard;
    took = 0;
    guard = 0;
    start = pulse;
    while (!took && !hung) begin
      cfg_if.s_valid = ($urandom_range(99) < duty);
      cfg_if.s_data  = cfg_if.s_valid ? d : 12'($urandom);
      took = cfg_if.s_valid && cfg_if.s_ready;
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (guard > 500 && !took) begin
        hung = 1;
        total++;
        bad++;
        $display("FAIL handshake_timeout: s_ready=%0b never accepted beat in 500 cycles", cfg_if.s_ready);
      end
    end
    cfg_if.s_valid = 1'b0;
  endtask

  task automatic load(input int mode, input int duty, input bit glitch, input int upto);
    for (int k = 0; k < upto && !hung; k++) begin
      coef_t d;
      case (mode)
        0:       d = 12'(NB - 1 - k);
        1:       d = '1;
        default: d = 12'($urandom);
      endcase
      send(d, duty, glitch && (k == 10 || k == 2000));
    end
  endtask

  task automatic arm(input int pm, input bit lat);
    wr_cnt = 0;
    bl_cnt = 0;
    pin_mode = pm;
    chk_lat = lat;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_check(input string nm);
    repeat (3) @(negedge clk);
    chk({nm, "_writes"}, wr_cnt, 36);
    chk({nm, "_bloads"}, bl_cnt, 1);
    chk({nm, "_hog_en"}, hog_en, 1);
    chk({nm, "_cfg_done"}, cfg_done, 1);
  endtask

  initial begin
    int snap;
    cfg_if.s_valid = 1'b0;
    cfg_if.s_data  = '0;

    // reset then idle
    repeat (5) @(negedge clk);
    chk("reset_outputs", {cfg_if.s_ready, write_en, busy, cfg_done, hog_en, b_load,
                          |addr_a, |i_data_a, |bias}, '0);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_outputs", {cfg_if.s_ready, write_en, busy, cfg_done, hog_en, b_load,
                           |addr_a, |i_data_a, |bias}, '0);
    end

    // full load, continuous valid
    arm(0, 1);
    pin_bias = 12'h0A0;
    pulse_start();
    load(0, 100, 0, NB);
    send(12'h0A0, 100, 0);
    finish_check("full");
    repeat (10) @(negedge clk);
    chk("hog_en_holds", hog_en, 1);

    // same data with 50% valid gaps
    arm(0, 0);
    pulse_start();
    load(0, 50, 0, NB);
    send(12'h0A0, 50, 0);
    finish_check("gaps");

    // stray start pulses mid-load
    arm(0, 0);
    pulse_start();
    load(0, 100, 1, NB);
    send(12'h0A0, 100, 0);
    finish_check("glitch");

    // reconfigure from DONE with all-ones coefficients
    arm(1, 0);
    pin_bias = 12'h5A5;
    chk("pre_reconfig_hog", hog_en, 1);
    pulse_start();
    chk("reconfig_drop", {cfg_done, hog_en}, 2'b00);
    load(1, 100, 0, NB);
    send(12'h5A5, 100, 0);
    finish_check("ones");

    // async reset at word 17 lane 50, then a fresh random load
    arm(2, 0);
    pulse_start();
    load(2, 100, 0, 17*105 + 50);
    #2 rst = 1'b0;
    #1 chk("abort_outputs", {cfg_if.s_ready, write_en, busy, cfg_done, hog_en, b_load,
                             |addr_a, |i_data_a, |bias}, '0);
    snap = wr_cnt;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_write_after_abort", wr_cnt, snap);
    chk("no_done_after_abort", {cfg_done, hog_en}, 2'b00);
    arm(2, 0);
    pin_bias = 12'h3C7;
    pulse_start();
    load(2, 75, 0, NB);
    send(12'h3C7, 100, 0);
    finish_check("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
